seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Time-multiplexed scan controller for the car's multi-digit 7-segment display. It sits between the control logic, which supplies packed 4-bit digit codes, and the shared SEG7_LUT decoder plus the active-low digit anodes. It sequences one digit at a time through the single decoder and inserts a guard cycle between digits to prevent ghosting. New display values are latched atomically at frame boundaries, so the display never tears.

## Interface
- `DIGITS`, default 4: number of digits scanned (2–8).
- `DIV`, default 50000: clk cycles per digit slot (minimum 2).
- `BLINK_FRAMES`, default 64: frames per blink half-period (only with SEG7_BLINK_EN).
- `clk`  in  1: system clock.
- `rst`  in  1: synchronous, active-high reset.
- `load`  in  1: single-cycle strobe; stages `data_in` for display.
- `data_in`  in  4*DIGITS: digit i code = `data_in[4i+3:4i]`, coded as the SEG7_LUT codes (4'hf = off).
- `blank_mask`  in  DIGITS: bit i = 1 keeps digit i dark. Sampled live each slot.
- `blink_mask`  in  DIGITS: bit i = 1 blinks digit i (only with SEG7_BLINK_EN).
- `upd_pend`  out  1: staged value not yet committed.
- `an`  out  DIGITS: active-low anodes, registered.
- `dig`  out  4: code currently presented to the decoder, registered.
- `seg`  out  7: decoder output, combinational from `dig`.

## Operation
- Registers:
  - `pend_r`: staged value.
  - `disp_r`: committed value.
  - `idx`: 0..DIGITS-1.
  - `cnt`: 0..DIV-1, width $clog2(DIV).
  - FSM state.
- FSM has two states:
  - GUARD: 1 cycle. `an` is all ones; `dig` updates to the code for `idx`. Always goes to DRIVE.
  - DRIVE: DIV-1 cycles. `an[idx]` = 0 and all other anode bits = 1.
- Slot end: at DRIVE with `cnt`==DIV-1 (the tick):
  - `idx` increments, wrapping DIGITS-1→0.
  - `cnt` clears and the FSM returns to GUARD.
- Commit: at the tick with `idx`==DIGITS-1 (frame end), if `upd_pend`, then `disp_r` ← `pend_r` and `upd_pend` clears.
- Load rules:
  - A `load` sets `pend_r` ← `data_in` and sets `upd_pend`.
  - A second `load` before commit overwrites `pend_r`; last write wins.
- Load on the commit cycle: `disp_r` ← `data_in` directly and `upd_pend` stays 0.
- Blanked digit: if `blank_mask[idx]` or the blink-off condition holds during a slot, `an` stays all ones for the whole slot and `dig` = 4'hf.
- `dig` for a lit digit is `disp_r[4*idx+3:4*idx]`, unmodified.

## Timing
- Reset values:
  - `an` = all ones, `dig` = 4'hf, `seg` = 7'b1111111, `upd_pend` = 0.
  - `disp_r` = all 4'hf, `pend_r` = 0, `idx` = 0, `cnt` = 0, FSM = GUARD.
- First anode goes low 1 cycle after `rst` deasserts; that is `an[0]`, showing blank until the first commit.
- Slot length is DIV cycles; frame length is DIGITS*DIV cycles.
- Load-to-visible latency: from the cycle after the strobe up to one full frame, plus the GUARD cycle of slot 0.
- `upd_pend` rises the cycle after `load` and falls the cycle after commit.
- Reset asserted mid-frame: all state returns to reset values the next edge and the staged value is discarded.

## Configuration
- `SEG7_BLINK_EN` defined:
  - Adds the `blink_mask` port and a frame counter to BLINK_FRAMES.
  - A blink phase bit toggles each BLINK_FRAMES frames, at frame end. It is reset to 1 (on).
  - While phase = 0, digits set in `blink_mask` are treated as blanked.
- Undefined: no port, no counter, no phase logic; the blanking condition is `blank_mask` only.

## Structure
- Shared package `seg7_pkg` holds:
  - Code constants `SEG7_CODE_OFF` = 4'hf and `SEG7_SEG_OFF` = 7'b1111111.
  - FSM state enum `seg7_scan_st_t` {GUARD, DRIVE}.
- One sub-module: `seg7_scan_timer`. It holds `cnt` and `idx` and emits `tick` and `frame_end`.
- SEG7_LUT is instantiated once inside `seg7_scan_ctrl`.

## Test plan
Use DIV=4, DIGITS=4.
- Reset: hold `rst` 3 cycles → `an`=4'b1111, `dig`=4'hf, `seg`=7'b1111111, `upd_pend`=0.
- Basic load: `load` with `data_in`=16'h1234 → `upd_pend`=1 until frame end. The next frame shows `dig` 4,3,2,1 with `an` 1110, 1101, 1011, 0111. Each slot is 1 guard cycle then 3 drive cycles; `seg` for digit 0 = 7'b0011001.
- Overwrite: load 16'hAAAA, then 16'h5678 in the same frame → only 5678 is ever displayed.
- Load on commit cycle: `load` 16'h9090 exactly at the frame-end tick → `upd_pend` stays 0; 9090 appears in the next frame.
- Blanking: `blank_mask`=4'b0100 → `an[2]` never 0; `dig`=4'hf during slot 2.
- Reset mid-frame and blink (with SEG7_BLINK_EN, BLINK_FRAMES=2):
  - `rst` mid-slot 2 with `upd_pend`=1 → next cycle returns to reset values and `upd_pend`=0.
  - `blink_mask`=4'b0001 → digit 0 dark for 2 frames, lit for 2 frames, repeating.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and FSM state type for the 7-segment scan path.
//   SEG7_CODE_OFF : decoder input code that lights no segment
//   SEG7_SEG_OFF  : active-low segment pattern with every segment dark
//   seg7_scan_st_t: scan FSM states
package seg7_pkg;
  localparam logic [3:0] SEG7_CODE_OFF = 4'hf;
  localparam logic [6:0] SEG7_SEG_OFF  = 7'b1111111;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } seg7_scan_st_t;
endpackage

// File: rtl/seg7_lut.sv
// SEG7_LUT: shared 4-bit code to active-low 7-segment decoder (gfedcba).
//   i_dig [3:0] : digit code; 4'hf is the "off" code
//   o_seg [6:0] : active-low segments, combinational
module SEG7_LUT
  import seg7_pkg::*;
(
  input  logic [3:0] i_dig,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = SEG7_SEG_OFF;
    case (i_dig)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0011000;
      4'ha: o_seg = 7'b0001000;
      4'hb: o_seg = 7'b0000011;
      4'hc: o_seg = 7'b1000110;
      4'hd: o_seg = 7'b0100001;
      4'he: o_seg = 7'b0000110;
      default: o_seg = SEG7_SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg7_scan_timer.sv
// seg7_scan_timer: slot cycle counter and digit index for the scan controller.
//   clk, rst      : clock, synchronous active-high reset
//   o_tick        : last cycle of a slot (cnt == DIV-1)
//   o_frame_end   : tick of the last digit slot
//   o_idx         : digit currently being scanned
module seg7_scan_timer #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      o_tick,
  output logic                      o_frame_end,
  output logic [$clog2(DIGITS)-1:0] o_idx
);
  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;
  logic [IW-1:0] r_idx;

  assign o_tick      = (r_cnt == CW'(DIV - 1));
  assign o_frame_end = o_tick && (r_idx == IW'(DIGITS - 1));
  assign o_idx       = r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
      r_idx <= o_frame_end ? '0 : r_idx + 1'b1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed scan of DIGITS 7-segment digits through one
// shared decoder, with a dark guard cycle between digits and tear-free updates
// committed only at frame end.
//   clk, rst    : clock, synchronous active-high reset
//   load        : strobe staging data_in for the next frame boundary
//   data_in     : packed digit codes, digit i at [4i+3:4i]
//   blank_mask  : 1 = digit dark, sampled each slot
//   blink_mask  : 1 = digit blinks (only when SEG7_BLINK_EN is defined)
//   upd_pend    : a staged value is waiting for frame end
//   an          : active-low anodes (registered)
//   dig         : code fed to the decoder (registered)
//   seg         : decoder output
// Optional feature macro: SEG7_BLINK_EN (blink phase and blink_mask port).
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int DIV          = 50000
`ifdef SEG7_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     blank_mask,
`ifdef SEG7_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic                  upd_pend,
  output logic [DIGITS-1:0]     an,
  output logic [3:0]            dig,
  output logic [6:0]            seg
);
  localparam int IW = $clog2(DIGITS);

  seg7_scan_st_t       r_state;
  logic [4*DIGITS-1:0] r_disp;
  logic [4*DIGITS-1:0] r_pend;
  logic                r_upd_pend;
  logic [DIGITS-1:0]   r_an;
  logic [3:0]          r_dig;

  logic                w_tick;
  logic                w_frame_end;
  logic [IW-1:0]       w_idx;
  logic [IW-1:0]       w_idx_nxt;
  logic [4*DIGITS-1:0] w_disp_nxt;
  logic                w_off_cur;
  logic                w_off_nxt;

  seg7_scan_timer #(.DIGITS(DIGITS), .DIV(DIV)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .o_tick      (w_tick),
    .o_frame_end (w_frame_end),
    .o_idx       (w_idx)
  );

  assign w_idx_nxt = w_frame_end ? '0 : w_idx + 1'b1;

  // A load landing on the commit edge bypasses staging and is shown directly.
  always_comb begin
    w_disp_nxt = r_disp;
    if (w_frame_end && load)            w_disp_nxt = data_in;
    else if (w_frame_end && r_upd_pend) w_disp_nxt = r_pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp     <= {DIGITS{SEG7_CODE_OFF}};
      r_pend     <= '0;
      r_upd_pend <= 1'b0;
    end else begin
      r_disp <= w_disp_nxt;
      if (w_frame_end) begin
        r_upd_pend <= 1'b0;
      end else if (load) begin
        r_pend     <= data_in;
        r_upd_pend <= 1'b1;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [FW-1:0] r_fcnt;
  logic          r_phase;
  logic          w_fwrap;
  logic          w_phase_nxt;

  assign w_fwrap     = w_frame_end && (r_fcnt == FW'(BLINK_FRAMES - 1));
  assign w_phase_nxt = w_fwrap ? ~r_phase : r_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fcnt  <= '0;
      r_phase <= 1'b1;
    end else if (w_frame_end) begin
      r_fcnt  <= w_fwrap ? '0 : r_fcnt + 1'b1;
      r_phase <= w_phase_nxt;
    end
  end

  assign w_off_cur = blank_mask[w_idx] | (~r_phase & blink_mask[w_idx]);
  assign w_off_nxt = blank_mask[w_idx_nxt] | (~w_phase_nxt & blink_mask[w_idx_nxt]);
`else
  assign w_off_cur = blank_mask[w_idx];
  assign w_off_nxt = blank_mask[w_idx_nxt];
`endif

  // dig is preloaded on entry to GUARD so the decoder settles with the
  // anodes off; it is refreshed on the GUARD edge from the same blank sample
  // that decides the anode, so the drive window is always consistent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= GUARD;
      r_an    <= '1;
      r_dig   <= SEG7_CODE_OFF;
    end else begin
      case (r_state)
        GUARD: begin
          r_state <= DRIVE;
          r_an    <= w_off_cur ? '1 : ~(DIGITS'(1) << w_idx);
          r_dig   <= w_off_cur ? SEG7_CODE_OFF : r_disp[{w_idx, 2'b00} +: 4];
        end
        DRIVE: begin
          if (w_tick) begin
            r_state <= GUARD;
            r_an    <= '1;
            r_dig   <= w_off_nxt ? SEG7_CODE_OFF : w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
          end
        end
        default: r_state <= GUARD;
      endcase
    end
  end

  SEG7_LUT u_lut (
    .i_dig (r_dig),
    .o_seg (seg)
  );

  assign an       = r_an;
  assign dig      = r_dig;
  assign upd_pend = r_upd_pend;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
module tb_seg7_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;
`ifdef SEG7_BLINK_EN
  localparam int BF     = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  blank_mask = '0;
`ifdef SEG7_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic        upd_pend;
  logic [3:0]  an;
  logic [3:0]  dig;
  logic [6:0]  seg;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time since reset release, shown/staged values.
  int          t = 0;
  logic [15:0] m_disp = 16'hffff;
  logic [15:0] m_pend_val = '0;
  logic        m_pend = 1'b0;
  logic        m_blk = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS (DIGITS),
    .DIV    (DIV)
`ifdef SEG7_BLINK_EN
    ,
    .BLINK_FRAMES (BF)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .blank_mask (blank_mask),
`ifdef SEG7_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .upd_pend   (upd_pend),
    .an         (an),
    .dig        (dig),
    .seg        (seg)
  );

  function automatic logic [6:0] lut(input logic [3:0] c);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b1111111};
    return tbl[c];
  endfunction

  function automatic int slot_of();
    return (t / DIV) % DIGITS;
  endfunction

  function automatic bit in_drive();
    return (t % DIV) != 0;
  endfunction

  function automatic logic [3:0] exp_an();
    logic [3:0] v;
    v = 4'hf;
    if (in_drive() && !m_blk) v[slot_of()] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] exp_dig();
    return m_blk ? 4'hf : m_disp[4*slot_of() +: 4];
  endfunction

  // One clock: capture the inputs the DUT will sample, then advance the model.
  task automatic step();
    logic       l, r;
    logic [15:0] d;
    logic [3:0] b;
`ifdef SEG7_BLINK_EN
    logic [3:0] bk;
    bk = blink_mask;
`endif
    l = load; r = rst; d = data_in; b = blank_mask;
    @(posedge clk); #1;
    if (r) begin
      t = 0; m_disp = 16'hffff; m_pend = 1'b0; m_pend_val = '0; m_blk = 1'b0;
      return;
    end
    if (t % DIV == 0) begin
`ifdef SEG7_BLINK_EN
      m_blk = b[slot_of()] | (bk[slot_of()] && (((t / FRAME) / BF) % 2 == 1));
`else
      m_blk = b[slot_of()];
`endif
    end
    if (t % FRAME == FRAME - 1) begin
      if (l) begin
        m_disp = d; m_pend = 1'b0;
      end else if (m_pend) begin
        m_disp = m_pend_val; m_pend = 1'b0;
      end
    end else if (l) begin
      m_pend_val = d; m_pend = 1'b1;
    end
    t++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    n_cmp++;
    if (an !== 4'b1111) begin n_bad++; $display("FAIL reset_an got %b want 1111", an); end
    n_cmp++;
    if (dig !== 4'hf) begin n_bad++; $display("FAIL reset_dig got %h want f", dig); end
    n_cmp++;
    if (seg !== 7'b1111111) begin n_bad++; $display("FAIL reset_seg got %b want 1111111", seg); end
    n_cmp++;
    if (upd_pend !== 1'b0) begin n_bad++; $display("FAIL reset_pend got %b want 0", upd_pend); end
    rst = 1'b0;
    step();
    n_cmp++;
    if (an !== 4'b1110 || dig !== 4'hf) begin
      n_bad++; $display("FAIL first_anode got an=%b dig=%h want an=1110 dig=f", an, dig);
    end
  endtask

  task automatic test_basic_load();
    load = 1'b1; data_in = 16'h1234; step(); load = 1'b0;
    n_cmp++;
    if (upd_pend !== 1'b1) begin n_bad++; $display("FAIL basic_pend_rise got %b want 1", upd_pend); end
    repeat (2 * FRAME) begin
      step();
      n_cmp++;
      if (an !== exp_an() || upd_pend !== m_pend ||
          (in_drive() && (dig !== exp_dig() || seg !== lut(exp_dig())))) begin
        n_bad++;
        $display("FAIL basic t=%0d got an=%b dig=%h seg=%b pend=%b want an=%b dig=%h seg=%b pend=%b",
                 t, an, dig, seg, upd_pend, exp_an(), exp_dig(), lut(exp_dig()), m_pend);
      end
    end
    // Land on a slot-0 drive cycle: 1234 must be shown with digit 0 = 4.
    while (!(slot_of() == 0 && t % DIV == 1)) step();
    n_cmp++;
    if (dig !== 4'h4 || seg !== 7'b0011001 || an !== 4'b1110) begin
      n_bad++; $display("FAIL basic_digit0 got an=%b dig=%h seg=%b want an=1110 dig=4 seg=0011001", an, dig, seg);
    end
  endtask

  task automatic test_overwrite();
    bit saw_a;
    saw_a = 1'b0;
    while (t % FRAME != 2) step();
    load = 1'b1; data_in = 16'hAAAA; step(); load = 1'b0;
    repeat (3) step();
    load = 1'b1; data_in = 16'h5678; step(); load = 1'b0;
    repeat (2 * FRAME) begin
      step();
      if (in_drive() && dig === 4'ha) saw_a = 1'b1;
      n_cmp++;
      if (an !== exp_an() || upd_pend !== m_pend ||
          (in_drive() && (dig !== exp_dig() || seg !== lut(exp_dig())))) begin
        n_bad++;
        $display("FAIL overwrite t=%0d got an=%b dig=%h pend=%b want an=%b dig=%h pend=%b",
                 t, an, dig, upd_pend, exp_an(), exp_dig(), m_pend);
      end
    end
    n_cmp++;
    if (saw_a) begin n_bad++; $display("FAIL overwrite_no_a got digit a shown want never"); end
  endtask

  task automatic test_load_on_commit();
    while (t % FRAME != FRAME - 1) step();
    load = 1'b1; data_in = 16'h9090; step(); load = 1'b0;
    n_cmp++;
    if (upd_pend !== 1'b0) begin n_bad++; $display("FAIL commit_load_pend got %b want 0", upd_pend); end
    repeat (FRAME + 2) begin
      step();
      n_cmp++;
      if (an !== exp_an() || upd_pend !== m_pend ||
          (in_drive() && (dig !== exp_dig() || seg !== lut(exp_dig())))) begin
        n_bad++;
        $display("FAIL commit_load t=%0d got an=%b dig=%h pend=%b want an=%b dig=%h pend=%b",
                 t, an, dig, upd_pend, exp_an(), exp_dig(), m_pend);
      end
    end
  endtask

  task automatic test_blanking();
    bit lit2;
    lit2 = 1'b0;
    blank_mask = 4'b0100;
    while (t % FRAME != FRAME - 1) step();
    repeat (2 * FRAME) begin
      step();
      if (an[2] === 1'b0) lit2 = 1'b1;
      n_cmp++;
      if (an !== exp_an() || upd_pend !== m_pend ||
          (in_drive() && (dig !== exp_dig() || seg !== lut(exp_dig())))) begin
        n_bad++;
        $display("FAIL blank t=%0d got an=%b dig=%h want an=%b dig=%h", t, an, dig, exp_an(), exp_dig());
      end
    end
    n_cmp++;
    if (lit2) begin n_bad++; $display("FAIL blank_an2 got an[2]=0 seen want never"); end
    blank_mask = 4'b0000;
  endtask

  task automatic test_random();
    repeat (600) begin
      load = ($urandom_range(0, 7) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) blank_mask = 4'($urandom);
      step();
      n_cmp++;
      if (an !== exp_an() || upd_pend !== m_pend ||
          (in_drive() && (dig !== exp_dig() || seg !== lut(exp_dig())))) begin
        n_bad++;
        $display("FAIL random t=%0d got an=%b dig=%h pend=%b want an=%b dig=%h pend=%b",
                 t, an, dig, upd_pend, exp_an(), exp_dig(), m_pend);
      end
    end
    load = 1'b0; blank_mask = 4'b0000;
  endtask

  task automatic test_reset_mid();
    while (t % FRAME != 0) step();
    load = 1'b1; data_in = 16'hBEEF; step(); load = 1'b0;
    while (t % FRAME != 2 * DIV + 2) step();
    n_cmp++;
    if (upd_pend !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_pend got %b want 1", upd_pend); end
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++;
    if (an !== 4'b1111 || dig !== 4'hf || seg !== 7'b1111111 || upd_pend !== 1'b0) begin
      n_bad++;
      $display("FAIL midrst_values got an=%b dig=%h seg=%b pend=%b want 1111 f 1111111 0", an, dig, seg, upd_pend);
    end
    repeat (2 * FRAME) begin
      step();
      n_cmp++;
      if (an !== exp_an() || upd_pend !== m_pend ||
          (in_drive() && (dig !== exp_dig() || seg !== lut(exp_dig())))) begin
        n_bad++;
        $display("FAIL midrst t=%0d got an=%b dig=%h pend=%b want an=%b dig=%h pend=%b",
                 t, an, dig, upd_pend, exp_an(), exp_dig(), m_pend);
      end
    end
  endtask

`ifdef SEG7_BLINK_EN
  task automatic test_blink();
    rst = 1'b1; step(); rst = 1'b0;
    blink_mask = 4'b0001;
    load = 1'b1; data_in = 16'h1234; step(); load = 1'b0;
    repeat (8 * FRAME) begin
      step();
      n_cmp++;
      if (an !== exp_an() || upd_pend !== m_pend ||
          (in_drive() && (dig !== exp_dig() || seg !== lut(exp_dig())))) begin
        n_bad++;
        $display("FAIL blink t=%0d got an=%b dig=%h want an=%b dig=%h", t, an, dig, exp_an(), exp_dig());
      end
    end
    blink_mask = 4'b0000;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_load();
    test_overwrite();
    test_load_on_commit();
    test_blanking();
    test_random();
    test_reset_mid();
`ifdef SEG7_BLINK_EN
    test_blink();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
